wb_regfile: RTL

Consumer end of the MEM/WB pipeline register: the writeback stage plus the architectural register file.
- Selects the writeback value from the MEM/WB outputs using the 2-bit MemtoReg select.
- Commits that value to a 32x32 register file on the clock edge.
- Serves two combinational read ports to ID, with write-first internal bypass.
- Keeps a committed-write counter for debug and performance.

---
 rtl/wb_regfile.sv | 71 +++++++
 1 files changed

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback select, 32x32 register file with write-first bypass, commit counter
module wb_regfile #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        MemtoReg_wb_i,
  input  logic              RegWrite_wb_i,
  input  logic [DATA_W-1:0] NPC_wb_i,
  input  logic [DATA_W-1:0] MD_wb_i,
  input  logic [DATA_W-1:0] ALUOut_wb_i,
  input  logic [DATA_W-1:0] EXT_wb_i,
  input  logic [DATA_W-1:0] RD_wb_i,
  input  logic [ADDR_W-1:0] RA1_i,
  input  logic [ADDR_W-1:0] RA2_i,
  output logic [DATA_W-1:0] RD1_o,
  output logic [DATA_W-1:0] RD2_o,
  output logic [DATA_W-1:0] WD_wb_o,
  output logic [ADDR_W-1:0] WA_wb_o,
  output logic              WE_wb_o,
  output logic [31:0]       wcount_o
);

  logic [DATA_W-1:0] regs_q [REG_NUM];
  logic [31:0]       wcount_q, wcount_d;
  logic              unused_rd_hi;

  // Upper destination bits carry no meaning for a 32-entry file.
  assign unused_rd_hi = ^RD_wb_i[DATA_W-1:ADDR_W];

  always_comb begin
    WD_wb_o = ALUOut_wb_i;
    unique case (MemtoReg_wb_i)
      2'b00: WD_wb_o = ALUOut_wb_i;
      2'b01: WD_wb_o = MD_wb_i;
      2'b10: WD_wb_o = NPC_wb_i;
      2'b11: WD_wb_o = EXT_wb_i;
    endcase
  end

  assign WA_wb_o  = RD_wb_i[ADDR_W-1:0];
  assign WE_wb_o  = RegWrite_wb_i && (WA_wb_o != '0);
  assign wcount_d = wcount_q + 32'd1;
  assign wcount_o = wcount_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      wcount_q <= '0;
    end else if (WE_wb_o) begin
      regs_q[WA_wb_o] <= WD_wb_o;
      wcount_q        <= wcount_d;
    end
  end

  // r0 reads as zero even if a bypass would otherwise match.
  always_comb begin
    RD1_o = regs_q[RA1_i];
    if (RA1_i == '0)                        RD1_o = '0;
    else if (WE_wb_o && RA1_i == WA_wb_o)   RD1_o = WD_wb_o;
  end

  always_comb begin
    RD2_o = regs_q[RA2_i];
    if (RA2_i == '0)                        RD2_o = '0;
    else if (WE_wb_o && RA2_i == WA_wb_o)   RD2_o = WD_wb_o;
  end

endmodule
